// File: rtl/multi_digit_ssd_ctrl.sv
// Multiplexed multi-digit seven-segment display controller.
// Scans NUM_DIGITS digits, CYCLE_PER_DIGIT clocks each, with double-buffered
// display data (shadow -> live at frame wrap), leading-zero suppression,
// per-digit blanking, decimal points and PWM brightness. Outputs active-low.
//
// load handshake: load is a single-cycle strobe with no ready; din, dp_sel and
// blank_mask are captured into the shadow in every cycle load=1 (last load
// wins), pending rises, and the shadow is promoted to the live register only
// at the next frame wrap so a frame is never torn.
module multi_digit_ssd_ctrl #(
  parameter int NUM_DIGITS      = 8,
  parameter int CYCLE_PER_DIGIT = 100000,
  parameter int BRIGHT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   dp_sel,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_blank,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic                    pending,
  output logic                    frame_done,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = (CYCLE_PER_DIGIT > 2) ? $clog2(CYCLE_PER_DIGIT) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BRIGHT_W-1:0]     r_pwm;
  logic [4*NUM_DIGITS-1:0] r_sh_din, r_lv_din;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_lv_dp;
  logic [NUM_DIGITS-1:0]   r_sh_bm, r_lv_bm;
  logic                    r_pending;
  logic                    r_frame_done;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_cnt_tc;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic                    w_bm_bit;
  logic                    w_lz_bit;
  logic [NUM_DIGITS-1:0]   w_lz_vec;
  logic                    w_lit;
  logic [6:0]              w_seg_dec;
  logic [NUM_DIGITS-1:0]   w_an;

  assign w_cnt_tc = (r_cnt == CNT_LAST);
  assign w_wrap   = w_cnt_tc && (r_idx == IDX_LAST);

  // Scan timing: per-digit cycle counter, digit index and free-running PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_pwm <= '0;
    end else begin
      r_pwm <= r_pwm + BRIGHT_W'(1);
      if (w_cnt_tc) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Double buffer: load fills the shadow, frame wrap promotes it to live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_din  <= '0;
      r_sh_dp   <= '0;
      r_sh_bm   <= '0;
      r_lv_din  <= '0;
      r_lv_dp   <= '0;
      r_lv_bm   <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_lv_din <= r_sh_din;
        r_lv_dp  <= r_sh_dp;
        r_lv_bm  <= r_sh_bm;
      end
      if (load) begin
        r_sh_din <= din;
        r_sh_dp  <= dp_sel;
        r_sh_bm  <= blank_mask;
      end
      if (load) begin
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Leading-zero flags: digit k>0 is a leading zero when live nibbles k..top are all zero.
  always_comb begin
    w_lz_vec = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_lz_vec[k] = (k != 0);
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (r_lv_din[4*j +: 4] != 4'h0) w_lz_vec[k] = 1'b0;
      end
    end
  end

  // Select the current digit's nibble, flags and anode pattern.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_bm_bit = 1'b0;
    w_lz_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib    = r_lv_din[4*i +: 4];
        w_dp_bit = r_lv_dp[i];
        w_bm_bit = r_lv_bm[i];
        w_lz_bit = lz_blank && w_lz_vec[i];
      end
    end
    w_lit = (r_pwm <= bright) && !w_bm_bit && !w_lz_bit;
    w_an  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_lit && (r_idx == IDX_W'(i))) w_an[i] = 1'b0;
    end
  end

  // Hex to active-low segment pattern, bit order g..a.
  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_nib)
      4'h0: w_seg_dec = 7'h40;
      4'h1: w_seg_dec = 7'h79;
      4'h2: w_seg_dec = 7'h24;
      4'h3: w_seg_dec = 7'h30;
      4'h4: w_seg_dec = 7'h19;
      4'h5: w_seg_dec = 7'h12;
      4'h6: w_seg_dec = 7'h02;
      4'h7: w_seg_dec = 7'h78;
      4'h8: w_seg_dec = 7'h00;
      4'h9: w_seg_dec = 7'h10;
      4'hA: w_seg_dec = 7'h08;
      4'hB: w_seg_dec = 7'h03;
      4'hC: w_seg_dec = 7'h46;
      4'hD: w_seg_dec = 7'h21;
      4'hE: w_seg_dec = 7'h06;
      4'hF: w_seg_dec = 7'h0E;
      default: w_seg_dec = 7'h7F;
    endcase
  end

  // Registered display outputs and frame strobe (one cycle behind scan state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_lit ? w_seg_dec : 7'h7F;
      r_dp         <= w_lit ? ~w_dp_bit : 1'b1;
      r_an         <= w_an;
      r_frame_done <= w_wrap;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule

// File: tb/tb_multi_digit_ssd_ctrl.sv
// Bench for multi_digit_ssd_ctrl: 8 digits, 4 cycles per digit, 2-bit brightness.
// Table of probe vectors, hand sequences for buffering and reset, then random
// traffic, all cross-checked every cycle against a time-based reference model.
module tb_multi_digit_ssd_ctrl;

  localparam int ND  = 8;
  localparam int CPD = 4;
  localparam int BW  = 2;
  localparam int FRAME = ND * CPD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   din = '0;
  logic [7:0]    dp_sel = '0;
  logic [7:0]    blank_mask = '0;
  logic          lz_blank = 1'b0;
  logic          load = 1'b0;
  logic [BW-1:0] bright = '1;
  logic          pending, frame_done, dp;
  logic [6:0]    seg;
  logic [7:0]    an;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  multi_digit_ssd_ctrl #(.NUM_DIGITS(ND), .CYCLE_PER_DIGIT(CPD), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst(rst), .din(din), .dp_sel(dp_sel), .blank_mask(blank_mask),
    .lz_blank(lz_blank), .load(load), .bright(bright), .pending(pending),
    .frame_done(frame_done), .seg(seg), .dp(dp), .an(an)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference model: scan position derived from elapsed cycles since reset.
  int unsigned m_t = 0;
  logic [31:0] m_sh_din = '0, m_lv_din = '0;
  logic [7:0]  m_sh_dp = '0, m_lv_dp = '0, m_sh_bm = '0, m_lv_bm = '0;
  logic        m_pend = 1'b0;
  logic [6:0]  m_seg = 7'h7F;
  logic        m_dp = 1'b1;
  logic [7:0]  m_an = 8'hFF;
  logic        m_fd = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_sh_din = '0; m_lv_din = '0; m_sh_dp = '0; m_lv_dp = '0;
      m_sh_bm = '0; m_lv_bm = '0; m_pend = 1'b0;
      m_seg = 7'h7F; m_dp = 1'b1; m_an = 8'hFF; m_fd = 1'b0;
    end else begin
      int d, ph;
      bit wrap, lead0, lit;
      d     = (m_t / CPD) % ND;
      ph    = m_t % (1 << BW);
      wrap  = (m_t % FRAME) == FRAME - 1;
      lead0 = (d > 0) && ((m_lv_din >> (4 * d)) == 32'h0);
      lit   = (ph <= int'(bright)) && !m_lv_bm[d] && !(lz_blank && lead0);
      m_seg = lit ? hex_seg(m_lv_din[4*d +: 4]) : 7'h7F;
      m_dp  = lit ? ~m_lv_dp[d] : 1'b1;
      m_an  = lit ? ~(8'h01 << d) : 8'hFF;
      m_fd  = wrap;
      if (wrap && m_pend) begin
        m_lv_din = m_sh_din; m_lv_dp = m_sh_dp; m_lv_bm = m_sh_bm; m_pend = 1'b0;
      end
      if (load) begin
        m_sh_din = din; m_sh_dp = dp_sel; m_sh_bm = blank_mask; m_pend = 1'b1;
      end
      m_t++;
    end
  end

  // Scoreboard against the model, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({seg, dp, an, frame_done, pending} !== {m_seg, m_dp, m_an, m_fd, m_pend}) begin
        n_bad++;
        $display("FAIL model t=%0t: seg=%h dp=%b an=%h fd=%b pend=%b expected seg=%h dp=%b an=%h fd=%b pend=%b",
                 $time, seg, dp, an, frame_done, pending, m_seg, m_dp, m_an, m_fd, m_pend);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dps, input logic [7:0] bm);
    din = d; dp_sel = dps; blank_mask = bm; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge where frame_done is high (scan state idx 0, cnt 0).
  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 4 * FRAME);
    check("frame_done_seen", {31'h0, frame_done}, 32'h1);
  endtask

  typedef struct {
    logic [31:0] din;
    logic [7:0]  dps;
    logic [7:0]  bm;
    logic        lz;
    logic [1:0]  br;
    int          dig;
    int          ph;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // reset
    repeat (3) @(negedge clk);
    check("rst_seg", {25'h0, seg}, 32'h7F);
    check("rst_dp", {31'h0, dp}, 32'h1);
    check("rst_an", {24'h0, an}, 32'hFF);
    check("rst_fd", {31'h0, frame_done}, 32'h0);
    check("rst_pending", {31'h0, pending}, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // probe table: load, wait for the frame it goes live, then look at one digit/pwm phase
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd3, 3, 0, 7'h30, 1'b1, 8'hF7});
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd3, 0, 3, 7'h40, 1'b1, 8'hFE});
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd3, 7, 2, 7'h78, 1'b1, 8'h7F});
    vecs.push_back('{32'h00000500, 8'h00, 8'h00, 1'b1, 2'd3, 2, 0, 7'h12, 1'b1, 8'hFB});
    vecs.push_back('{32'h00000500, 8'h00, 8'h00, 1'b1, 2'd3, 3, 0, 7'h7F, 1'b1, 8'hFF});
    vecs.push_back('{32'h00000500, 8'h00, 8'h00, 1'b1, 2'd3, 1, 0, 7'h40, 1'b1, 8'hFD});
    vecs.push_back('{32'h00000500, 8'h00, 8'h00, 1'b1, 2'd3, 0, 1, 7'h40, 1'b1, 8'hFE});
    vecs.push_back('{32'h00000500, 8'h00, 8'h00, 1'b1, 2'd3, 7, 0, 7'h7F, 1'b1, 8'hFF});
    vecs.push_back('{32'h00000500, 8'h00, 8'h00, 1'b0, 2'd3, 5, 0, 7'h40, 1'b1, 8'hDF});
    vecs.push_back('{32'h00000000, 8'h00, 8'h00, 1'b1, 2'd3, 0, 0, 7'h40, 1'b1, 8'hFE});
    vecs.push_back('{32'h00000000, 8'h00, 8'h00, 1'b1, 2'd3, 1, 0, 7'h7F, 1'b1, 8'hFF});
    vecs.push_back('{32'h76543210, 8'h81, 8'h02, 1'b0, 2'd3, 0, 0, 7'h40, 1'b0, 8'hFE});
    vecs.push_back('{32'h76543210, 8'h81, 8'h02, 1'b0, 2'd3, 7, 0, 7'h78, 1'b0, 8'h7F});
    vecs.push_back('{32'h76543210, 8'h81, 8'h02, 1'b0, 2'd3, 1, 0, 7'h7F, 1'b1, 8'hFF});
    vecs.push_back('{32'h76543210, 8'h81, 8'h02, 1'b0, 2'd3, 2, 0, 7'h24, 1'b1, 8'hFB});
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd0, 4, 0, 7'h19, 1'b1, 8'hEF});
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd0, 4, 1, 7'h7F, 1'b1, 8'hFF});
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd0, 4, 3, 7'h7F, 1'b1, 8'hFF});
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd1, 4, 1, 7'h19, 1'b1, 8'hEF});
    vecs.push_back('{32'h76543210, 8'h00, 8'h00, 1'b0, 2'd1, 4, 2, 7'h7F, 1'b1, 8'hFF});
    vecs.push_back('{32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 2'd3, 7, 0, 7'h0E, 1'b1, 8'h7F});
    vecs.push_back('{32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 2'd3, 2, 0, 7'h08, 1'b1, 8'hFB});
    vecs.push_back('{32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 2'd3, 0, 0, 7'h00, 1'b1, 8'hFE});
    vecs.push_back('{32'hFEDCBA98, 8'h00, 8'h00, 1'b0, 2'd3, 5, 0, 7'h21, 1'b1, 8'hDF});

    @(negedge clk);
    for (int v = 0; v < vecs.size(); v++) begin
      lz_blank = vecs[v].lz;
      bright   = vecs[v].br;
      do_load(vecs[v].din, vecs[v].dps, vecs[v].bm);
      wait_fd();
      check($sformatf("vec%0d_pending", v), {31'h0, pending}, 32'h0);
      repeat (CPD * vecs[v].dig + vecs[v].ph + 1) @(negedge clk);
      check($sformatf("vec%0d_seg", v), {25'h0, seg}, {25'h0, vecs[v].seg});
      check($sformatf("vec%0d_dp", v), {31'h0, dp}, {31'h0, vecs[v].dp});
      check($sformatf("vec%0d_an", v), {24'h0, an}, {24'h0, vecs[v].an});
    end

    // full scan walk: each digit's anode low for all 4 cycles of its slot
    lz_blank = 1'b0; bright = 2'd3;
    do_load(32'h76543210, 8'h00, 8'h00);
    wait_fd();
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      check($sformatf("walk_an%0d", k), {24'h0, an}, {24'h0, ~(8'h01 << (k / CPD))});
    end

    // A loaded mid-frame, B loaded in the wrap cycle: A next frame, B the frame after
    wait_fd();
    repeat (4) @(negedge clk);
    do_load(32'h00000001, 8'h00, 8'h00);
    check("ab_pending_a", {31'h0, pending}, 32'h1);
    repeat (FRAME - 6) @(negedge clk);
    din = 32'h00000002; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("ab_wrap_fd", {31'h0, frame_done}, 32'h1);
    check("ab_pending_wrap", {31'h0, pending}, 32'h1);
    @(negedge clk);
    check("ab_show_a", {25'h0, seg}, 32'h79);
    wait_fd();
    check("ab_pending_b", {31'h0, pending}, 32'h0);
    @(negedge clk);
    check("ab_show_b", {25'h0, seg}, 32'h24);

    // reset mid-slot with a pending load
    repeat (5) @(negedge clk);
    do_load(32'h12345678, 8'hFF, 8'h00);
    @(negedge clk);
    check("rst2_pending_before", {31'h0, pending}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst2_seg", {25'h0, seg}, 32'h7F);
    check("rst2_dp", {31'h0, dp}, 32'h1);
    check("rst2_an", {24'h0, an}, 32'hFF);
    check("rst2_fd", {31'h0, frame_done}, 32'h0);
    check("rst2_pending", {31'h0, pending}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst2_restart_seg", {25'h0, seg}, 32'h40);
    check("rst2_restart_an", {24'h0, an}, 32'hFE);
    check("rst2_restart_dp", {31'h0, dp}, 32'h1);

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 9) == 0);
      if (load) begin
        din        = $urandom() >> (4 * $urandom_range(0, 8));
        dp_sel     = 8'($urandom());
        blank_mask = 8'($urandom() & $urandom() & $urandom());
      end
      if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom());
      if ($urandom_range(0, 15) == 0) bright = BW'($urandom());
    end
    @(negedge clk);
    load = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
